// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit.
// Owns the HI/LO registers. mult/multu/div/divu compute their result in the
// issue cycle into temp registers, then hold busy for a fixed latency before
// committing to HI/LO. mthi/mtlo write directly while idle.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  S_IDLE | no operation in flight; accepts MD ops and mthi/mtlo
//  S_RUN  | latency counter running; HI/LO committed on its final edge
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hi_sel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDout
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   temp_hi_q, temp_hi_d;
    logic [31:0]   temp_lo_q, temp_lo_d;
    logic          commit_q, commit_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          busy_q, busy_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    logic [31:0] q_mag, r_mag;
    logic [31:0] quot_s, rem_s;
    logic [31:0] quot_u, rem_u;
    logic        b_zero;

    // Arithmetic datapath; signed divide works on magnitudes so the
    // 0x80000000 / -1 case wraps to 0x80000000 with a zero remainder.
    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};
        a_neg  = A[31];
        b_neg  = B[31];
        mag_a  = a_neg ? (32'd0 - A) : A;
        mag_b  = b_neg ? (32'd0 - B) : B;
        b_zero = (B == 32'd0);
        q_mag  = 32'd0;
        r_mag  = 32'd0;
        quot_u = 32'd0;
        rem_u  = 32'd0;
        if (!b_zero) begin
            q_mag  = mag_a / mag_b;
            r_mag  = mag_a % mag_b;
            quot_u = A / B;
            rem_u  = A % B;
        end
        quot_s = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem_s  = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        temp_hi_d = temp_hi_q;
        temp_lo_d = temp_lo_q;
        commit_d  = commit_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            temp_hi_d = (op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
                            temp_lo_d = (op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
                            commit_d  = 1'b1;
                            cnt_d     = CW'(MULT_CYCLES);
                            busy_d    = 1'b1;
                            state_d   = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            temp_hi_d = (op == OP_DIV) ? rem_s  : rem_u;
                            temp_lo_d = (op == OP_DIV) ? quot_s : quot_u;
                            // divide by zero still burns the latency but leaves HI/LO alone
                            commit_d  = !b_zero;
                            cnt_d     = CW'(DIV_CYCLES);
                            busy_d    = 1'b1;
                            state_d   = S_RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    if (commit_q) begin
                        hi_d = temp_hi_q;
                        lo_d = temp_lo_q;
                    end
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            temp_hi_q <= 32'd0;
            temp_lo_q <= 32'd0;
            commit_q  <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            temp_hi_q <= temp_hi_d;
            temp_lo_q <= temp_lo_d;
            commit_q  <= commit_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
        end
    end

    // Outputs; MDout shows only committed HI/LO.
    always_comb begin
        busy  = busy_q;
        HI    = hi_q;
        LO    = lo_q;
        MDout = hi_sel ? hi_q : lo_q;
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: scoreboard of expected {HI,LO} values.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_sel;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDout;

    int vectors;
    int miscompares;

    logic [63:0] sb_q[$];
    logic [31:0] sh_hi;
    logic [31:0] sh_lo;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .hi_sel (hi_sel),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .MDout  (MDout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
        longint sa, sb, p, qq, rr;
        longint unsigned ua, ub, up, uq, ur;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = {h, l};
        case (o)
            3'd1: begin p = sa * sb; res = p; end
            3'd2: begin up = ua * ub; res = up; end
            3'd3: if (b != 32'd0) begin
                qq = sa / sb;
                rr = sa % sb;
                res = {rr[31:0], qq[31:0]};
            end
            3'd4: if (b != 32'd0) begin
                uq = ua / ub;
                ur = ua % ub;
                res = {ur[31:0], uq[31:0]};
            end
            3'd5: res = {a, l};
            3'd6: res = {h, a};
            default: ;
        endcase
        return res;
    endfunction

    // Caller is positioned just after a negedge; drives one start cycle.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd0;
    endtask

    task automatic push_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        e = model(o, a, b, sh_hi, sh_lo);
        sh_hi = e[63:32];
        sh_lo = e[31:0];
        sb_q.push_back(e);
    endtask

    // Counts negedges with busy high until busy is seen low (bounded).
    task automatic wait_idle(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (busy) cyc++;
            else ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        int cyc;
        bit ok;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy actual=%b required=0", busy); end
        vectors++;
        if (HI !== 32'd0) begin miscompares++; $display("FAIL reset_hi actual=%h required=0", HI); end
        vectors++;
        if (LO !== 32'd0) begin miscompares++; $display("FAIL reset_lo actual=%h required=0", LO); end
        // abort a mult mid-run
        issue(3'd1, 32'd2, 32'd3);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_mid_busy actual=%b required=0", busy); end
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_abort actual busy=%b hi=%h lo=%h required busy=0 hi=0 lo=0", busy, HI, LO);
        end
        sh_hi = 32'd0;
        sh_lo = 32'd0;
        cyc = 0;
        ok = 1'b1;
    endtask

    task automatic run_checked(input string name, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] want, input int n);
        int cyc;
        bit ok;
        logic [63:0] e;
        sh_hi = want[63:32];
        sh_lo = want[31:0];
        sb_q.push_back(want);
        issue(o, a, b);
        wait_idle(cyc, ok);
        vectors++;
        if (!ok || cyc != n) begin
            miscompares++;
            $display("FAIL %s_busy actual=%0d cycles done=%0d required=%0d", name, cyc, ok, n);
        end
        e = sb_q.pop_front();
        vectors++;
        if ({HI, LO} !== e) begin
            miscompares++;
            $display("FAIL %s_result actual=%h_%h required=%h_%h", name, HI, LO, e[63:32], e[31:0]);
        end
    endtask

    task automatic test_mult;
        @(negedge clk);
        run_checked("mult",  3'd1, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 5);
        run_checked("multu", 3'd2, 32'hFFFFFFFE, 32'd3, 64'h00000002_FFFFFFFA, 5);
    endtask

    task automatic test_div;
        run_checked("div",     3'd3, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 10);
        run_checked("divu",    3'd4, 32'd7, 32'd2, 64'h00000001_00000003, 10);
        run_checked("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 10);
    endtask

    task automatic test_div_zero;
        issue(3'd5, 32'h1234, 32'd0);
        issue(3'd6, 32'h1234, 32'd0);
        @(negedge clk);
        run_checked("divu_zero", 3'd4, 32'd5, 32'd0, 64'h00001234_00001234, 10);
    endtask

    task automatic test_mthi_mtlo;
        bit seen_busy;
        logic [63:0] e;
        seen_busy = 1'b0;
        @(negedge clk);
        push_op(3'd5, 32'hDEADBEEF, 32'd0);
        issue(3'd5, 32'hDEADBEEF, 32'd0);
        seen_busy |= busy;
        push_op(3'd6, 32'h0BADF00D, 32'd0);
        issue(3'd6, 32'h0BADF00D, 32'd0);
        seen_busy |= busy;
        @(negedge clk);
        seen_busy |= busy;
        void'(sb_q.pop_front());
        e = sb_q.pop_front();
        hi_sel = 1'b1;
        #1;
        vectors++;
        if (MDout !== e[63:32]) begin miscompares++; $display("FAIL mfhi actual=%h required=%h", MDout, e[63:32]); end
        hi_sel = 1'b0;
        #1;
        vectors++;
        if (MDout !== e[31:0]) begin miscompares++; $display("FAIL mflo actual=%h required=%h", MDout, e[31:0]); end
        @(negedge clk);
        seen_busy |= busy;
        vectors++;
        if (seen_busy !== 1'b0) begin miscompares++; $display("FAIL mt_busy actual=%b required=0", seen_busy); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        bit ok;
        logic [63:0] e;
        push_op(3'd3, 32'd100, 32'd7);
        issue(3'd3, 32'd100, 32'd7);
        @(negedge clk);
        // mult during the div run must be ignored
        issue(3'd1, 32'd9, 32'd9);
        wait_idle(cyc, ok);
        cyc = cyc + 1;
        vectors++;
        if (!ok || cyc != 10) begin
            miscompares++;
            $display("FAIL b2b_div_busy actual=%0d done=%0d required=10", cyc, ok);
        end
        e = sb_q.pop_front();
        vectors++;
        if ({HI, LO} !== e) begin
            miscompares++;
            $display("FAIL b2b_div_result actual=%h_%h required=%h_%h", HI, LO, e[63:32], e[31:0]);
        end
        // first idle cycle after busy falls
        run_checked("b2b_mult", 3'd1, 32'd5, 32'd6, 64'd30, 5);
    endtask

    task automatic test_random;
        int cyc;
        bit ok;
        logic [63:0] e;
        logic [2:0] o;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(1, 4));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
            if (i == 0) b = 32'd0;
            push_op(o, a, b);
            issue(o, a, b);
            wait_idle(cyc, ok);
            vectors++;
            if (!ok || cyc != ((o <= 3'd2) ? 5 : 10)) begin
                miscompares++;
                $display("FAIL rand%0d_busy op=%0d actual=%0d done=%0d", i, o, cyc, ok);
            end
            e = sb_q.pop_front();
            vectors++;
            if ({HI, LO} !== e) begin
                miscompares++;
                $display("FAIL rand%0d_result op=%0d a=%h b=%h actual=%h_%h required=%h_%h",
                         i, o, a, b, HI, LO, e[63:32], e[31:0]);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        sh_hi       = 32'd0;
        sh_lo       = 32'd0;
        reset       = 1'b0;
        start       = 1'b0;
        op          = 3'd0;
        A           = 32'd0;
        B           = 32'd0;
        hi_sel      = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_mthi_mtlo();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
